// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit encodings, length width, injector FSM states
// and small helpers used by the injector, arbiter and timer.
package noc_pkg;

  // Packet length field width; matches the arbiter timer length port.
  localparam int NOC_LEN_W = 12;

  typedef logic [2:0] flit_id_t;

  localparam flit_id_t FLIT_IDLE = 3'b000;
  localparam flit_id_t FLIT_HEAD = 3'b001;
  localparam flit_id_t FLIT_BODY = 3'b010;
  localparam flit_id_t FLIT_TAIL = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_HEAD    = 2'd2,
    ST_PAYLOAD = 2'd3
  } inj_state_e;

  // Increment an 8-bit counter, sticking at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] val);
    logic [7:0] res;
    if (val == 8'hFF) begin
      res = val;
    end else begin
      res = val + 8'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/packet_injector_if.sv
// Bundle of descriptor, payload, arbiter and flit signals of the injector.
// slave is the injector side, master is the side that feeds and observes it.
interface packet_injector_if
  import noc_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LEN_W  = NOC_LEN_W
);

  logic              desc_valid;
  logic [LEN_W-1:0]  desc_len;
  logic              desc_ready;
  logic              data_valid;
  logic [DATA_W-1:0] data_in;
  logic              data_ready;
  logic              grant;
  logic              req;
  logic              flit_valid;
  flit_id_t          flit_id;
  logic [LEN_W-1:0]  length;
  logic [DATA_W-1:0] flit_data;
  logic              pkt_done;
  logic [7:0]        preempt_cnt;

  modport master (
    output desc_valid, desc_len, data_valid, data_in, grant,
    input  desc_ready, data_ready, req, flit_valid, flit_id, length,
           flit_data, pkt_done, preempt_cnt
  );

  modport slave (
    input  desc_valid, desc_len, data_valid, data_in, grant,
    output desc_ready, data_ready, req, flit_valid, flit_id, length,
           flit_data, pkt_done, preempt_cnt
  );

endinterface

// File: rtl/flit_counter.sv
// Loadable down-counter tracking the payload flits still to be sent.
// is_last flags the final flit so the injector can tag it as tail.
module flit_counter
  import noc_pkg::*;
#(
  parameter int LEN_W = NOC_LEN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [LEN_W-1:0] load_val,
  input  logic             dec,
  output logic [LEN_W-1:0] cnt,
  output logic             is_last
);

  logic [LEN_W-1:0] cnt_r;

  // Load on descriptor acceptance, count down once per payload flit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (dec && (cnt_r != '0)) begin
      cnt_r <= cnt_r - LEN_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt     = cnt_r;
  assign is_last = (cnt_r == LEN_W'(1));

endmodule

// File: rtl/packet_injector.sv
// Packet injector: takes a length descriptor, requests the arbiter, and
// emits a header flit followed by N payload flits (last one tagged tail).
// Grant loss mid-packet pauses the stream and is counted; flits resume
// at the next unsent payload word without resending the header.
module packet_injector
  import noc_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LEN_W  = NOC_LEN_W
) (
  input logic              clk,
  input logic              rst,
  packet_injector_if.slave bus
);

  inj_state_e        state_r;
  logic              desc_ready_r;
  logic              req_r;
  logic              flit_valid_r;
  flit_id_t          flit_id_r;
  logic [DATA_W-1:0] flit_data_r;
  logic [LEN_W-1:0]  length_r;
  logic              pkt_done_r;
  logic [7:0]        preempt_r;
  logic [LEN_W-1:0]  len_q_r;
  logic              grant_q_r;

  logic              accept_s;
  logic              in_pkt_s;
  logic              data_ready_s;
  logic              hs_s;
  logic              drop_s;
  logic [LEN_W-1:0]  remaining_s;
  logic              is_last_s;

  assign accept_s     = bus.desc_valid && desc_ready_r && (state_r == ST_IDLE);
  assign in_pkt_s     = (state_r == ST_PAYLOAD) || (state_r == ST_HEAD);
  assign data_ready_s = in_pkt_s && bus.grant;
  assign hs_s         = data_ready_s && bus.data_valid;
  // A preemption is a falling edge of grant while a packet is in flight.
  assign drop_s       = in_pkt_s && !bus.grant && grant_q_r;

  flit_counter #(.LEN_W(LEN_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (accept_s),
    .load_val (bus.desc_len),
    .dec      (hs_s),
    .cnt      (remaining_s),
    .is_last  (is_last_s)
  );

  // Injector FSM with all flit/handshake outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      desc_ready_r <= 1'b0;
      req_r        <= 1'b0;
      flit_valid_r <= 1'b0;
      flit_id_r    <= FLIT_IDLE;
      flit_data_r  <= '0;
      length_r     <= '0;
      pkt_done_r   <= 1'b0;
      preempt_r    <= 8'd0;
      len_q_r      <= '0;
      grant_q_r    <= 1'b0;
    end else begin
      flit_valid_r <= 1'b0;
      flit_id_r    <= FLIT_IDLE;
      flit_data_r  <= '0;
      pkt_done_r   <= 1'b0;
      grant_q_r    <= bus.grant;
      if (drop_s) begin
        preempt_r <= sat_inc8(preempt_r);
      end else begin
        preempt_r <= preempt_r;
      end
      case (state_r)
        ST_IDLE: begin
          // desc_ready rises one cycle after entering IDLE, so no descriptor
          // is taken in the cycle that shows the tail flit.
          if (accept_s) begin
            len_q_r      <= bus.desc_len;
            desc_ready_r <= 1'b0;
            req_r        <= 1'b1;
            state_r      <= ST_REQ;
          end else begin
            desc_ready_r <= 1'b1;
            state_r      <= ST_IDLE;
          end
        end
        ST_REQ: begin
          if (bus.grant) begin
            flit_valid_r <= 1'b1;
            flit_id_r    <= FLIT_HEAD;
            flit_data_r  <= DATA_W'(len_q_r);
            length_r     <= len_q_r;
            if (len_q_r == '0) begin
              pkt_done_r <= 1'b1;
              req_r      <= 1'b0;
              state_r    <= ST_IDLE;
            end else begin
              state_r    <= ST_PAYLOAD;
            end
          end else begin
            state_r <= ST_REQ;
          end
        end
        ST_HEAD, ST_PAYLOAD: begin
          if (hs_s) begin
            flit_valid_r <= 1'b1;
            flit_data_r  <= bus.data_in;
            if (is_last_s) begin
              flit_id_r  <= FLIT_TAIL;
              pkt_done_r <= 1'b1;
              req_r      <= 1'b0;
              state_r    <= ST_IDLE;
            end else begin
              flit_id_r  <= FLIT_BODY;
              state_r    <= ST_PAYLOAD;
            end
          end else if (!bus.grant && (remaining_s == len_q_r)) begin
            // Preempted before the first payload word left.
            state_r <= ST_HEAD;
          end else begin
            state_r <= state_r;
          end
        end
        default: begin
          desc_ready_r <= 1'b0;
          req_r        <= 1'b0;
          state_r      <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.desc_ready  = desc_ready_r;
  assign bus.data_ready  = data_ready_s;
  assign bus.req         = req_r;
  assign bus.flit_valid  = flit_valid_r;
  assign bus.flit_id     = flit_id_r;
  assign bus.flit_data   = flit_data_r;
  assign bus.length      = length_r;
  assign bus.pkt_done    = pkt_done_r;
  assign bus.preempt_cnt = preempt_r;

endmodule

// File: tb/tb_packet_injector.sv
// Directed bench for packet_injector with a flit scoreboard.
module tb_packet_injector;

  typedef struct {
    logic [2:0]  id;
    logic [31:0] data;
    logic        done;
    logic [11:0] len;
  } exp_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   pkt_base;
  int   word_idx;
  logic hs_v;
  exp_t exp_q[$];

  packet_injector_if #(.DATA_W(32), .LEN_W(12)) pif ();

  packet_injector #(.DATA_W(32), .LEN_W(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (pif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stream source: word k of the overall payload stream is A000_0000 + k.
  assign pif.data_in = 32'hA000_0000 + 32'(word_idx);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Expected header plus the first cnt payload flits of an n-flit packet.
  task automatic push_pkt(input int n, input int cnt);
    exp_t e;
    e.id   = 3'b001;
    e.data = 32'(n);
    e.done = (n == 0);
    e.len  = 12'(n);
    exp_q.push_back(e);
    for (int k = 0; k < cnt; k++) begin
      e.id   = (k == n - 1) ? 3'b100 : 3'b010;
      e.data = 32'hA000_0000 + 32'(pkt_base + k);
      e.done = (k == n - 1);
      exp_q.push_back(e);
    end
    pkt_base += cnt;
  endtask

  task automatic send_desc(input int n);
    int g;
    g = 0;
    pif.desc_valid = 1'b1;
    pif.desc_len   = 12'(n);
    while (!pif.desc_ready && g < 20) begin
      tick();
      g++;
    end
    chk("desc_ready_wait", 32'(pif.desc_ready), 32'd1);
    tick();
    pif.desc_valid = 1'b0;
    chk("req_up", 32'(pif.req), 32'd1);
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 6000) begin
      tick();
      g++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_desc_ready"}, 32'(pif.desc_ready), 32'd0);
    chk({tag, "_req"}, 32'(pif.req), 32'd0);
    chk({tag, "_flit_valid"}, 32'(pif.flit_valid), 32'd0);
    chk({tag, "_flit_id"}, 32'(pif.flit_id), 32'd0);
    chk({tag, "_length"}, 32'(pif.length), 32'd0);
    chk({tag, "_flit_data"}, pif.flit_data, 32'd0);
    chk({tag, "_pkt_done"}, 32'(pif.pkt_done), 32'd0);
    chk({tag, "_preempt"}, 32'(pif.preempt_cnt), 32'd0);
    chk({tag, "_data_ready"}, 32'(pif.data_ready), 32'd0);
  endtask

  // Monitor: sample 2 time units after each rising edge, score every flit.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      hs_v = pif.data_valid && pif.data_ready;
      #2;
      if (hs_v) word_idx++;
      if (rst) begin
        if (pif.flit_valid) begin
          chk("flit_pending", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("flit_id", 32'(pif.flit_id), 32'(e.id));
            chk("flit_data", pif.flit_data, e.data);
            chk("pkt_done", 32'(pif.pkt_done), 32'(e.done));
            chk("length", 32'(pif.length), 32'(e.len));
          end
        end else begin
          chk("idle_flit", 32'({pif.pkt_done, pif.flit_id}), 32'd0);
        end
      end
    end
  end

  initial begin
    total = 0; bad = 0; pkt_base = 0; word_idx = 0;
    rst = 1'b0;
    pif.desc_valid = 1'b0; pif.desc_len = 12'd0;
    pif.data_valid = 1'b0; pif.grant = 1'b0;
    tick(); tick();
    chk_all_zero("rst");
    rst = 1'b1;
    tick();
    chk("rst_rel_desc_ready", 32'(pif.desc_ready), 32'd1);

    // grant in IDLE is ignored
    pif.grant = 1'b1;
    tick(); tick();
    chk("idle_grant_req", 32'(pif.req), 32'd0);
    chk("idle_grant_dr", 32'(pif.data_ready), 32'd0);
    chk("idle_grant_fv", 32'(pif.flit_valid), 32'd0);
    pif.grant = 1'b0;

    // N=3, grant two cycles after req
    push_pkt(3, 3);
    send_desc(3);
    tick();
    chk("t1_wait_fv", 32'(pif.flit_valid), 32'd0);
    tick();
    pif.grant = 1'b1; pif.data_valid = 1'b1;
    tick();
    chk("t1_hdr", 32'(pif.flit_id), 32'd1);
    chk("t1_dr", 32'(pif.data_ready), 32'd1);
    tick();
    chk("t1_b0", 32'(pif.flit_id), 32'd2);
    tick();
    chk("t1_b1", 32'(pif.flit_id), 32'd2);
    tick();
    chk("t1_tail", 32'(pif.flit_id), 32'd4);
    chk("t1_done", 32'(pif.pkt_done), 32'd1);
    chk("t1_req_low", 32'(pif.req), 32'd0);
    chk("t1_no_desc", 32'(pif.desc_ready), 32'd0);
    pif.grant = 1'b0; pif.data_valid = 1'b0;
    tick();
    chk("t1_after", 32'(pif.flit_valid), 32'd0);
    wait_drain();

    // N=0: header only
    push_pkt(0, 0);
    send_desc(0);
    pif.grant = 1'b1;
    #1 chk("t2_dr_req", 32'(pif.data_ready), 32'd0);
    tick();
    chk("t2_hdr", 32'(pif.flit_id), 32'd1);
    chk("t2_done", 32'(pif.pkt_done), 32'd1);
    chk("t2_req", 32'(pif.req), 32'd0);
    chk("t2_dr", 32'(pif.data_ready), 32'd0);
    pif.grant = 1'b0;
    wait_drain();

    // N=5, grant dropped after 2nd payload flit for 4 cycles
    push_pkt(5, 5);
    send_desc(5);
    pif.grant = 1'b1; pif.data_valid = 1'b1;
    tick(); tick(); tick();
    chk("t3_b1", 32'(pif.flit_id), 32'd2);
    pif.grant = 1'b0;
    #1 chk("t3_dr_drop", 32'(pif.data_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3_drop_fv", 32'(pif.flit_valid), 32'd0);
      chk("t3_drop_req", 32'(pif.req), 32'd1);
    end
    chk("t3_preempt", 32'(pif.preempt_cnt), 32'd1);
    pif.grant = 1'b1;
    tick();
    chk("t3_r0", 32'(pif.flit_id), 32'd2);
    tick();
    chk("t3_r1", 32'(pif.flit_id), 32'd2);
    tick();
    chk("t3_tail", 32'(pif.flit_id), 32'd4);
    pif.grant = 1'b0; pif.data_valid = 1'b0;
    wait_drain();

    // N=4, data_valid gap of 3 cycles
    push_pkt(4, 4);
    send_desc(4);
    pif.grant = 1'b1; pif.data_valid = 1'b1;
    tick();
    chk("t4_len_hdr", 32'(pif.length), 32'd4);
    tick();
    pif.data_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_gap_fv", 32'(pif.flit_valid), 32'd0);
      chk("t4_gap_len", 32'(pif.length), 32'd4);
    end
    pif.data_valid = 1'b1;
    tick();
    chk("t4_b1", 32'(pif.flit_id), 32'd2);
    tick(); tick();
    chk("t4_tail", 32'(pif.flit_id), 32'd4);
    chk("t4_len_tail", 32'(pif.length), 32'd4);
    chk("t4_preempt", 32'(pif.preempt_cnt), 32'd1);
    pif.grant = 1'b0; pif.data_valid = 1'b0;
    wait_drain();

    // N=10, reset after 4 flits, then fresh N=2
    push_pkt(10, 3);
    send_desc(10);
    pif.grant = 1'b1; pif.data_valid = 1'b1;
    tick(); tick(); tick(); tick();
    chk("t5_4th_fv", 32'(pif.flit_valid), 32'd1);
    chk("t5_q", 32'(exp_q.size()), 32'd0);
    rst = 1'b0;
    #1 chk_all_zero("t5_rst");
    pif.grant = 1'b0; pif.data_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    push_pkt(2, 2);
    send_desc(2);
    pif.grant = 1'b1; pif.data_valid = 1'b1;
    tick();
    chk("t5_hdr", 32'(pif.flit_id), 32'd1);
    chk("t5_hdr_data", pif.flit_data, 32'd2);
    tick(); tick();
    chk("t5_tail", 32'(pif.flit_id), 32'd4);
    pif.grant = 1'b0; pif.data_valid = 1'b0;
    wait_drain();

    // 300 grant drops saturate preempt_cnt
    push_pkt(2, 2);
    send_desc(2);
    pif.grant = 1'b1;
    tick();
    chk("t6_hdr", 32'(pif.flit_id), 32'd1);
    for (int i = 0; i < 300; i++) begin
      pif.grant = 1'b0;
      tick();
      pif.grant = 1'b1;
      tick();
      if (i == 99) chk("t6_p100", 32'(pif.preempt_cnt), 32'd100);
    end
    chk("t6_p255", 32'(pif.preempt_cnt), 32'd255);
    chk("t6_no_flit", 32'(exp_q.size()), 32'd2);
    pif.data_valid = 1'b1;
    tick(); tick();
    chk("t6_tail", 32'(pif.flit_id), 32'd4);
    pif.grant = 1'b0; pif.data_valid = 1'b0;
    wait_drain();

    // N=4095, no wrap of the remaining counter
    push_pkt(4095, 4095);
    send_desc(4095);
    pif.grant = 1'b1; pif.data_valid = 1'b1;
    tick();
    chk("t7_hdr_data", pif.flit_data, 32'd4095);
    repeat (4095) tick();
    chk("t7_tail", 32'(pif.flit_id), 32'd4);
    chk("t7_done", 32'(pif.pkt_done), 32'd1);
    chk("t7_len", 32'(pif.length), 32'd4095);
    pif.grant = 1'b0; pif.data_valid = 1'b0;
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
